// File: rtl/pd_aux_mc.sv
// Multi-slice auxiliary phase detector: per-slice error-count / min-tracking loops that steer
// the main-PD offsets. Define PD_AUX_MC_LOCK_EN to add the per-slice reversal lock detector.
module pd_aux_mc #(
  parameter int Nadc       = 8,
  parameter int Nti        = 4,
  parameter int Ncntr      = 8,
  parameter int Nc_invalid = 3,
  parameter int Nfr        = 1,
  parameter int Dy0        = 1,
  parameter int Nrev       = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [Nadc*Nti-1:0] din,
  input  logic [Nadc*Nti-1:0] pd_offset_ext,
  input  logic                load_ext,
  output logic [Nadc*Nti-1:0] pd_offset,
  output logic [Nti-1:0]      pd_dir,
  output logic [Nti-1:0]      locked,
  output logic                win_done
);

  localparam int NACC = Nadc + Nfr;
  localparam int NERR = Ncntr + 1;
  localparam logic [Ncntr-1:0]       VALID_START = Ncntr'(2**Nc_invalid - 1);
  localparam logic [Nadc-1:0]        DY_STEP     = Nadc'(Dy0);
  localparam logic [Nadc-1:0]        ABS_MAX     = {1'b0, {(Nadc-1){1'b1}}};
  localparam logic signed [NACC+1:0] ACC_MAX     = $signed({3'b000, {(NACC-1){1'b1}}});
  localparam logic signed [NACC+1:0] ACC_MIN     = $signed({3'b111, {(NACC-1){1'b0}}});
  localparam logic signed [NACC+1:0] STEP1       = (NACC+2)'(1);
  localparam logic signed [NACC+1:0] STEP2       = (NACC+2)'(2);

  typedef enum logic [1:0] {IDLE, FIRST, TRACK} state_t;

  state_t           state, state_next;
  logic [Ncntr-1:0] cntr;
  logic             restart, decide_first, decide_track;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable) state_next = FIRST;
      FIRST: begin
        if (!enable)       state_next = IDLE;
        else if (load_ext) state_next = FIRST;
        else if (&cntr)    state_next = TRACK;
      end
      TRACK: begin
        if (!enable)       state_next = IDLE;
        else if (load_ext) state_next = FIRST;
      end
      default:             state_next = IDLE;
    endcase
  end

  // Any restart (reset, disable, idle, external reload) preloads every slice and overrides a decision.
  always_comb begin
    restart      = rst || !enable || load_ext || (state == IDLE);
    win_done     = (state != IDLE) && (&cntr);
    decide_first = !restart && (state == FIRST) && (&cntr);
    decide_track = !restart && (state == TRACK) && (&cntr);
  end

  always_ff @(posedge clk) begin
    if (restart) cntr <= '0;
    else         cntr <= cntr + Ncntr'(1);
  end

  for (genvar k = 0; k < Nti; k++) begin : g_slice
    logic [Nadc-1:0]          d, ext, abs_d, thr, dmin, dmin_new, dmin_prev, dy, dy_inc;
    logic [Nadc:0]            thr_sum, dy_sum;
    logic [NERR-1:0]          err, err_prev;
    logic [NACC-1:0]          acc, acc_next;
    logic signed [NACC+1:0]   step, acc_sum;
    logic                     dir, rise, frozen;

    assign d   = din[k*Nadc +: Nadc];
    assign ext = pd_offset_ext[k*Nadc +: Nadc];

    // The most negative code has no positive twin, so its magnitude clips to full scale.
    always_comb begin
      abs_d = d;
      if (d[Nadc-1]) abs_d = (d[Nadc-2:0] == '0) ? ABS_MAX : (~d + Nadc'(1));
    end

    always_comb begin
      thr_sum  = {1'b0, dmin_prev} + {1'b0, dy};
      thr      = thr_sum[Nadc] ? '1 : thr_sum[Nadc-1:0];
      dy_sum   = {1'b0, dy} + {1'b0, DY_STEP};
      dy_inc   = dy_sum[Nadc] ? '1 : dy_sum[Nadc-1:0];
      dmin_new = (abs_d < dmin) ? abs_d : dmin;
      rise     = err > err_prev;
    end

    always_comb begin
      if (rise)            step = dir ? -STEP1 : STEP1;
      else if (err == '0)  step = dir ? STEP1 : -STEP1;
      else                 step = dir ? STEP2 : -STEP2;
      acc_sum  = $signed({{2{acc[NACC-1]}}, acc}) + step;
      acc_next = acc_sum[NACC-1:0];
      if (acc_sum > ACC_MAX)      acc_next = ACC_MAX[NACC-1:0];
      else if (acc_sum < ACC_MIN) acc_next = ACC_MIN[NACC-1:0];
    end

    // Statistics always run; only the decision is gated by the FIRST window and by lock.
    always_ff @(posedge clk) begin
      if (restart) begin
        acc       <= {ext, {Nfr{1'b0}}};
        dir       <= 1'b1;
        dy        <= DY_STEP;
        err_prev  <= '0;
        dmin_prev <= '1;
        err       <= '0;
        dmin      <= '1;
      end else begin
        if (cntr == '0) begin
          err  <= '0;
          dmin <= '1;
        end else if (cntr >= VALID_START) begin
          err  <= err + NERR'(abs_d < thr);
          dmin <= dmin_new;
        end
        if (decide_first) begin
          err_prev  <= err;
          dmin_prev <= dmin;
        end else if (decide_track && !frozen) begin
          acc <= acc_next;
          if (rise) begin
            dir       <= !dir;
            dy        <= DY_STEP;
            dmin_prev <= dmin;
            err_prev  <= err;
          end else if (err == '0) begin
            dy       <= dy_inc;
            err_prev <= '1;
          end else begin
            err_prev <= err;
          end
        end
      end
    end

`ifdef PD_AUX_MC_LOCK_EN
    localparam int NREV = $clog2(Nrev + 1);
    logic [NREV-1:0] rev;
    logic            lock_q;

    always_ff @(posedge clk) begin
      if (restart) begin
        rev    <= '0;
        lock_q <= 1'b0;
      end else if (decide_track && !lock_q) begin
        if (rise) begin
          rev <= rev + NREV'(1);
          if (rev == NREV'(Nrev - 1)) lock_q <= 1'b1;
        end else begin
          rev <= '0;
        end
      end
    end

    assign frozen    = lock_q;
    assign locked[k] = lock_q;
`else
    assign frozen    = 1'b0;
    assign locked[k] = 1'b0;
`endif

    assign pd_offset[k*Nadc +: Nadc] = acc[NACC-1 -: Nadc];
    assign pd_dir[k]                 = dir;
  end

endmodule

// File: tb/tb_pd_aux_mc.sv
// Randomized bench for pd_aux_mc against a window-level behavioural model.
module tb_pd_aux_mc;
  localparam int NADC = 8, NTI = 4, WIN = 256, VSTART = 7;
`ifdef PD_AUX_MC_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst, enable, load_ext, win_done;
  logic [NADC*NTI-1:0] din, pd_offset_ext, pd_offset;
  logic [NTI-1:0]      pd_dir, locked;

  always #5 clk = ~clk;

  pd_aux_mc dut (
    .clk(clk), .rst(rst), .enable(enable), .din(din), .pd_offset_ext(pd_offset_ext),
    .load_ext(load_ext), .pd_offset(pd_offset), .pd_dir(pd_dir), .locked(locked),
    .win_done(win_done)
  );

  int checks = 0, errors = 0, cyc = 0;

  // Model: phase 0 idle, 1 first window, 2 tracking; offsets kept in half-LSB units.
  int m_phase, m_pos, m_n;
  int m_off2[NTI], m_dir[NTI], m_dy[NTI], m_eprev[NTI], m_dprev[NTI], m_rev[NTI], m_lock[NTI];
  int m_samp[NTI][WIN];
  int w_lvl[NTI], w_jit[NTI], w_zeros[NTI], w_usemin[NTI];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int sliceVal(input logic [31:0] v, input int k);
    logic signed [7:0] t;
    t = v[k*8 +: 8];
    return int'(t);
  endfunction

  function automatic logic [7:0] genSample(input int k);
    int v;
    if (w_zeros[k] > 0 && m_pos >= VSTART && m_pos < VSTART + w_zeros[k]) return 8'd0;
    v = w_lvl[k] + ((w_jit[k] > 0) ? int'($urandom_range(0, w_jit[k])) : 0);
    if (v > 127) v = 127;
    if ($urandom_range(0, 1) == 1) v = -v;
    if (w_usemin[k] != 0 && (v == 127 || v == -127) && $urandom_range(0, 1) == 1) v = -128;
    return v[7:0];
  endfunction

  task automatic modelDecide(input int k);
    int thr, err, mn, s;
    thr = m_dprev[k] + m_dy[k];
    if (thr > 255) thr = 255;
    err = 0;
    mn  = 255;
    for (int i = 0; i < m_n; i++) begin
      if (m_samp[k][i] < thr) err++;
      if (m_samp[k][i] < mn)  mn = m_samp[k][i];
    end
    if (m_phase == 1) begin
      m_eprev[k] = err;
      m_dprev[k] = mn;
    end else if (m_lock[k] == 0) begin
      s = (m_dir[k] != 0) ? 1 : -1;
      if (err > m_eprev[k]) begin
        m_off2[k] -= s;
        m_dir[k]   = 1 - m_dir[k];
        m_dy[k]    = 1;
        m_dprev[k] = mn;
        m_eprev[k] = err;
        m_rev[k]++;
        if (LOCK_EN && m_rev[k] >= 4) m_lock[k] = 1;
      end else if (err == 0) begin
        m_off2[k] += s;
        m_dy[k]    = (m_dy[k] + 1 > 255) ? 255 : m_dy[k] + 1;
        m_eprev[k] = 511;
        m_rev[k]   = 0;
      end else begin
        m_off2[k] += 2 * s;
        m_eprev[k] = err;
        m_rev[k]   = 0;
      end
      if (m_off2[k] > 255)  m_off2[k] = 255;
      if (m_off2[k] < -256) m_off2[k] = -256;
    end
  endtask

  task automatic modelStep();
    int a;
    if (rst || !enable || load_ext || m_phase == 0) begin
      for (int k = 0; k < NTI; k++) begin
        m_off2[k] = 2 * sliceVal(pd_offset_ext, k);
        m_dir[k] = 1; m_dy[k] = 1; m_eprev[k] = 0; m_dprev[k] = 255; m_rev[k] = 0; m_lock[k] = 0;
      end
      m_n = 0;
      m_pos = 0;
      m_phase = (rst || !enable) ? 0 : 1;
    end else begin
      if (m_pos >= VSTART && m_pos <= WIN - 2) begin
        for (int k = 0; k < NTI; k++) begin
          a = sliceVal(din, k);
          m_samp[k][m_n] = (a == -128) ? 127 : ((a < 0) ? -a : a);
        end
        m_n++;
      end
      if (m_pos == WIN - 1) begin
        for (int k = 0; k < NTI; k++) modelDecide(k);
        m_n = 0;
        if (m_phase == 1) m_phase = 2;
      end
      m_pos = (m_pos + 1) % WIN;
    end
  endtask

  task automatic applyStimulus();
    logic [31:0] expo;
    logic [3:0]  expd, expl;
    int          t;
    for (int k = 0; k < NTI; k++) din[k*8 +: 8] = genSample(k);
    @(posedge clk);
    modelStep();
    @(negedge clk);
    cyc++;
    if (m_pos <= 1 || m_pos >= WIN - 2 || (cyc % 37) == 0) begin
      for (int k = 0; k < NTI; k++) begin
        t = m_off2[k] >>> 1;
        expo[k*8 +: 8] = t[7:0];
        expd[k] = (m_dir[k] != 0);
        expl[k] = (m_lock[k] != 0);
      end
      checkOutput("pd_offset", pd_offset, expo);
      checkOutput("pd_dir", {28'd0, pd_dir}, {28'd0, expd});
      checkOutput("locked", {28'd0, locked}, {28'd0, expl});
      checkOutput("win_done", {31'd0, win_done}, {31'd0, (m_phase != 0 && m_pos == WIN - 1)});
    end
  endtask

  task automatic runWindow();
    int n = 0;
    do begin
      applyStimulus();
      n++;
    end while (m_pos != 0 && n < WIN + 8);
    if (m_pos != 0) checkOutput("window_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitDecision(input int ph);
    int n = 0;
    while (!(m_phase == ph && m_pos == WIN - 1) && n < WIN + 8) begin
      applyStimulus();
      n++;
    end
    if (!(m_phase == ph && m_pos == WIN - 1)) checkOutput("decision_timeout", 32'd0, 32'd1);
  endtask

  task automatic setWindow(input int lvl, input int jit, input int zeros, input int usemin);
    for (int k = 0; k < NTI; k++) begin
      w_lvl[k] = lvl; w_jit[k] = jit; w_zeros[k] = zeros; w_usemin[k] = usemin;
    end
  endtask

  task automatic randomWindows(input int n);
    for (int w = 0; w < n; w++) begin
      for (int k = 0; k < NTI; k++) begin
        w_lvl[k]    = $urandom_range(0, 100);
        w_jit[k]    = $urandom_range(0, 30);
        w_zeros[k]  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 40)) : 0;
        w_usemin[k] = $urandom_range(0, 1);
      end
      runWindow();
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    m_phase = 0; m_pos = 0; m_n = 0;
    rst = 1'b1; enable = 1'b0; load_ext = 1'b0; din = '0;
    pd_offset_ext = {8'd127, 8'd0, 8'hFD, 8'd5};
    setWindow(20, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus();
    checkOutput("reset_offset", pd_offset, 32'h7F00FD05);
    checkOutput("reset_dir", {28'd0, pd_dir}, 32'h0000000F);
    checkOutput("reset_locked", {28'd0, locked}, 32'd0);
    checkOutput("reset_win_done", {31'd0, win_done}, 32'd0);

    rst = 1'b0; enable = 1'b1;
    waitDecision(1);
    checkOutput("first_win_done", {31'd0, win_done}, 32'd1);
    applyStimulus();
    checkOutput("first_no_step", pd_offset, 32'h7F00FD05);
    waitDecision(2);
    checkOutput("second_win_done", {31'd0, win_done}, 32'd1);
    applyStimulus();
    checkOutput("second_step", pd_offset, 32'h7F01FE06);

    // Rising levels keep the error count at zero; slice 3 must pin at +127.
    for (int w = 0; w < 5; w++) begin
      setWindow((w == 4) ? 127 : 30 + 20 * w, 0, 0, (w == 4) ? 1 : 0);
      waitDecision(2);
      applyStimulus();
    end
    checkOutput("sat_slice3", {24'd0, pd_offset[31:24]}, 32'd127);

    randomWindows(12);

    waitDecision(2);
    pd_offset_ext = {8'd3, 8'h80, 8'd60, 8'h9C};
    load_ext = 1'b1;
    applyStimulus();
    load_ext = 1'b0;
    checkOutput("load_ext_offset", pd_offset, 32'h03803C9C);
    checkOutput("load_ext_dir", {28'd0, pd_dir}, 32'h0000000F);

    // Strictly growing error counts give consecutive reversals.
    setWindow(50, 0, 4, 0);
    runWindow();
    for (int z = 8; z <= 128; z = z * 2) begin
      setWindow(50, 0, z, 0);
      runWindow();
    end
    setWindow(50, 0, 128, 0);
    runWindow();
    runWindow();
    checkOutput("lock_state", {28'd0, locked}, LOCK_EN ? 32'h0000000F : 32'd0);

    enable = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus();
    checkOutput("disable_locked", {28'd0, locked}, 32'd0);
    checkOutput("disable_offset", pd_offset, 32'h03803C9C);

    enable = 1'b1;
    randomWindows(4);
    for (int i = 0; i < 40; i++) applyStimulus();
    rst = 1'b1;
    pd_offset_ext = {8'h81, 8'd100, 8'd0, 8'hFF};
    applyStimulus();
    applyStimulus();
    checkOutput("midrun_reset", pd_offset, 32'h816400FF);
    rst = 1'b0;
    randomWindows(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
